// File: rtl/apb_master_pkg.sv
// Shared types and default constants for the APB requester controller.
package apb_master_pkg;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_master_ctrl.sv
// APB requester: turns one valid/ready command into one APB transfer and
// returns the result on a valid/ready response channel.
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master_ctrl
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  // A zero-cycle timeout has no meaning; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("apb_master_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_t            state_q, state_d;
  logic                  cmd_ready_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  tmo_expire_c;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_timeout_d;

  // Last permitted ACCESS cycle reached with no PREADY.
  assign tmo_expire_c = (state_q == ACCESS) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS cycles; cleared everywhere else.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ACCESS && !PREADY && !tmo_expire_c) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Timeout counter and timeout flag registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tmo_cnt_q   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end
`else
  assign tmo_expire_c = 1'b0;
  assign rsp_timeout  = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout;
`endif
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY || tmo_expire_c) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pwdata_d    = '0;
          rsp_valid_d = 1'b1;
          if (PREADY) begin
            rsp_rdata_d = PWRITE ? '0 : PRDATA;
            rsp_err_d   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
          end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_d = 1'b1;
`endif
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: latency, wait states, slave error,
// response backpressure, optional timeout and mid-transfer reset.
module tb_apb_master_ctrl;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
  endtask

  initial begin
    int cnt;
    RESETN = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

    // Reset values
    repeat (3) cycle();
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    RESETN = 1'b1;
    cycle();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write, zero wait states, response consumed in its first cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0004; cmd_wdata = 32'h0000_00A5;
    PREADY = 1'b1; rsp_ready = 1'b1;
    check("wr_accept_ready", 32'(cmd_ready), 32'd1);
    cycle();                                   // N+1
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF;
    check("wr_n1_psel", 32'(PSEL), 32'd1);
    check("wr_n1_penable", 32'(PENABLE), 32'd0);
    check("wr_n1_paddr", PADDR, 32'h0000_0004);
    check("wr_n1_pwdata", PWDATA, 32'h0000_00A5);
    check("wr_n1_pwrite", 32'(PWRITE), 32'd1);
    check("wr_n1_cmd_ready", 32'(cmd_ready), 32'd0);
    cycle();                                   // N+2
    check("wr_n2_psel", 32'(PSEL), 32'd1);
    check("wr_n2_penable", 32'(PENABLE), 32'd1);
    check("wr_n2_paddr", PADDR, 32'h0000_0004);
    cycle();                                   // N+3
    check("wr_n3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_n3_rsp_err", 32'(rsp_err), 32'd0);
    check("wr_n3_rsp_rdata", rsp_rdata, 32'd0);
    check("wr_n3_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("wr_n3_psel", 32'(PSEL), 32'd0);
    check("wr_n3_paddr", PADDR, 32'd0);
    cycle();
    check("wr_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read with 3 wait states, then held response with a pending command
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_wdata = 32'h1234_5678;
    cycle();
    cmd_valid = 1'b0;
    check("rd_setup_pwdata", PWDATA, 32'd0);
    check("rd_setup_pwrite", 32'(PWRITE), 32'd0);
    check("rd_setup_paddr", PADDR, 32'h0000_0010);
    cycle();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (PENABLE) cnt++;
      check("rd_wait_psel", 32'(PSEL), 32'd1);
      check("rd_wait_paddr", PADDR, 32'h0000_0010);
      cycle();
    end
    PREADY = 1'b1;
    if (PENABLE) cnt++;
    cycle();
    PREADY = 1'b0;
    check("rd_penable_cycles", 32'(cnt), 32'd4);
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", 32'(rsp_err), 32'd0);
    check("rd_penable_off", 32'(PENABLE), 32'd0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0020; cmd_wdata = 32'h5555_AAAA;
    PRDATA = 32'h0BAD_F00D; PREADY = 1'b1; PSLVERR = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_psel", 32'(PSEL), 32'd0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("hold_rsp_err", 32'(rsp_err), 32'd0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1; PSLVERR = 1'b0;
    cycle();
    rsp_ready = 1'b0;
    check("rd_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rd_done_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write completing with a slave error
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0008; cmd_wdata = 32'h0000_0001;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hFFFF_FFFF;
    cycle(); cmd_valid = 1'b0;
    cycle();
    cycle();
    PSLVERR = 1'b0;
    check("err_rsp_valid", 32'(rsp_valid), 32'd1);
    check("err_rsp_err", 32'(rsp_err), 32'd1);
    check("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("err_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
    // Completer never ready: abort after 16 ACCESS cycles
    PREADY = 1'b0; PRDATA = 32'hCAFE_0000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0040;
    cycle(); cmd_valid = 1'b0;
    cycle();
    cnt = 0;
    while (PENABLE && cnt < 100) begin
      cnt++;
      cycle();
    end
    check("tmo_access_cycles", 32'(cnt), 32'd16);
    check("tmo_psel", 32'(PSEL), 32'd0);
    check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
    check("tmo_rsp_err", 32'(rsp_err), 32'd1);
    check("tmo_rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("tmo_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
`endif

    // Reset pulsed in the middle of ACCESS
    PREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030;
    cycle(); cmd_valid = 1'b0;
    cycle();
    check("rr_in_access", 32'(PENABLE), 32'd1);
    #2 RESETN = 1'b0;
    #1;
    check("rr_async_psel", 32'(PSEL), 32'd0);
    check("rr_async_penable", 32'(PENABLE), 32'd0);
    cycle();
    PREADY = 1'b1;
    RESETN = 1'b1;
    cycle();
    check("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    cycle();
    check("rr_rsp_valid_late", 32'(rsp_valid), 32'd0);
    check("rr_psel_idle", 32'(PSEL), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
